// File: rtl/reg_file_mp_if.sv
// Bundles the SPU-Lite register file ports: six read ports, two write ports
// and the status flags. The pipeline side uses "master" and the register
// file uses "slave".
interface reg_file_mp_if #(
  parameter int DATA_WD  = 128,
  parameter int SLOT_WD  = 32,
  parameter int RADDR_WD = 7
);
  localparam int NSLOT = DATA_WD / SLOT_WD;

  logic [RADDR_WD-1:0] ra_addr_ep, rb_addr_ep, rc_addr_ep;
  logic [RADDR_WD-1:0] ra_addr_op, rb_addr_op, rc_addr_op;
  logic [DATA_WD-1:0]  ra_rd_ep, rb_rd_ep, rc_rd_ep;
  logic [DATA_WD-1:0]  ra_rd_op, rb_rd_op, rc_rd_op;
  logic [RADDR_WD-1:0] rt_addr_ep, rt_addr_op;
  logic                rt_wr_en_ep, rt_wr_en_op;
  logic [NSLOT-1:0]    rt_wr_mask_ep, rt_wr_mask_op;
  logic [DATA_WD-1:0]  rt_wr_ep, rt_wr_op;
  logic                init_busy, wr_conflict, wr_drop;

  modport master (
    output ra_addr_ep, rb_addr_ep, rc_addr_ep, ra_addr_op, rb_addr_op, rc_addr_op,
    output rt_addr_ep, rt_addr_op, rt_wr_en_ep, rt_wr_en_op,
    output rt_wr_mask_ep, rt_wr_mask_op, rt_wr_ep, rt_wr_op,
    input  ra_rd_ep, rb_rd_ep, rc_rd_ep, ra_rd_op, rb_rd_op, rc_rd_op,
    input  init_busy, wr_conflict, wr_drop
  );

  modport slave (
    input  ra_addr_ep, rb_addr_ep, rc_addr_ep, ra_addr_op, rb_addr_op, rc_addr_op,
    input  rt_addr_ep, rt_addr_op, rt_wr_en_ep, rt_wr_en_op,
    input  rt_wr_mask_ep, rt_wr_mask_op, rt_wr_ep, rt_wr_op,
    output ra_rd_ep, rb_rd_ep, rc_rd_ep, ra_rd_op, rb_rd_op, rc_rd_op,
    output init_busy, wr_conflict, wr_drop
  );
endinterface

// File: rtl/reg_file_mp.sv
// Dual-issue register file for the SPU-Lite even/odd pipes: 3 read ports and
// 1 masked write port per pipe, same-cycle write bypass, op-over-ep priority
// on same-address writes, and a sequenced block clear after reset.
module reg_file_mp #(
  parameter int NUM_REGS    = 128,
  parameter int DATA_WD     = 128,
  parameter int SLOT_WD     = 32,
  parameter int RADDR_WD    = $clog2(NUM_REGS),
  parameter int CLR_PER_CYC = 4,
  parameter int BYPASS_EN   = 1
) (
  input logic          clk,
  input logic          rst,
  reg_file_mp_if.slave bus
);
  localparam int NSLOT = DATA_WD / SLOT_WD;
  localparam int NRD   = 6;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state, state_nxt;
  logic [RADDR_WD-1:0] clr_ptr, clr_ptr_nxt;
  logic                clr_last;
  logic                conflict_q, drop_q;
  logic [NSLOT-1:0]    ep_eff, op_eff;
  logic                same_addr;
  logic [DATA_WD-1:0]  regs [NUM_REGS];
  logic [RADDR_WD-1:0] rd_addr [NRD];
  logic [DATA_WD-1:0]  rd_data [NRD];

  // A disabled write behaves exactly like an all-zero mask.
  assign ep_eff    = bus.rt_wr_en_ep ? bus.rt_wr_mask_ep : '0;
  assign op_eff    = bus.rt_wr_en_op ? bus.rt_wr_mask_op : '0;
  assign same_addr = (bus.rt_addr_ep == bus.rt_addr_op);
  assign clr_last  = (clr_ptr == RADDR_WD'(NUM_REGS - CLR_PER_CYC));

  assign rd_addr[0] = bus.ra_addr_ep;
  assign rd_addr[1] = bus.rb_addr_ep;
  assign rd_addr[2] = bus.rc_addr_ep;
  assign rd_addr[3] = bus.ra_addr_op;
  assign rd_addr[4] = bus.rb_addr_op;
  assign rd_addr[5] = bus.rc_addr_op;

  assign bus.ra_rd_ep    = rd_data[0];
  assign bus.rb_rd_ep    = rd_data[1];
  assign bus.rc_rd_ep    = rd_data[2];
  assign bus.ra_rd_op    = rd_data[3];
  assign bus.rb_rd_op    = rd_data[4];
  assign bus.rc_rd_op    = rd_data[5];
  assign bus.init_busy   = (state == CLEAR);
  assign bus.wr_conflict = conflict_q;
  assign bus.wr_drop     = drop_q;

  // FSM state and clear pointer register; reset always restarts the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // Next-state logic: walk the array one block per cycle, then go READY.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      CLEAR: begin
        clr_ptr_nxt = clr_ptr + RADDR_WD'(CLR_PER_CYC);
        if (clr_last) begin
          state_nxt   = READY;
          clr_ptr_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  // Status pulses describe what happened to the writes of the previous cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      conflict_q <= (state == READY) && same_addr && (|(ep_eff & op_eff));
      drop_q     <= (state == CLEAR) && (bus.rt_wr_en_ep || bus.rt_wr_en_op);
    end
  end

  // Array update: block clear while CLEAR, masked writes while READY. The op
  // write is issued after ep so overlapping slots of a same-address pair
  // take the odd-pipe data. A reset edge leaves the array untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        for (int k = 0; k < CLR_PER_CYC; k++) begin
          regs[clr_ptr + RADDR_WD'(k)] <= '0;
        end
      end else begin
        for (int s = 0; s < NSLOT; s++) begin
          if (ep_eff[s]) regs[bus.rt_addr_ep][s*SLOT_WD +: SLOT_WD] <= bus.rt_wr_ep[s*SLOT_WD +: SLOT_WD];
        end
        for (int s = 0; s < NSLOT; s++) begin
          if (op_eff[s]) regs[bus.rt_addr_op][s*SLOT_WD +: SLOT_WD] <= bus.rt_wr_op[s*SLOT_WD +: SLOT_WD];
        end
      end
    end
  end

  // Combinational reads: zero during clear, otherwise stored data with the
  // pending write slots (op over ep) forwarded when bypass is enabled.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_data[p] = '0;
      if (state == READY) begin
        rd_data[p] = regs[rd_addr[p]];
        if (BYPASS_EN != 0) begin
          for (int s = 0; s < NSLOT; s++) begin
            if (op_eff[s] && (bus.rt_addr_op == rd_addr[p])) begin
              rd_data[p][s*SLOT_WD +: SLOT_WD] = bus.rt_wr_op[s*SLOT_WD +: SLOT_WD];
            end else if (ep_eff[s] && (bus.rt_addr_ep == rd_addr[p])) begin
              rd_data[p][s*SLOT_WD +: SLOT_WD] = bus.rt_wr_ep[s*SLOT_WD +: SLOT_WD];
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a bypassing and a non-bypassing instance share the
// same stimulus and are compared against a slot-level reference model.
module tb_reg_file_mp;
  localparam int NUM_REGS = 128;
  localparam int DATA_WD  = 128;
  localparam int NCLRCYC  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_mp_if bus ();
  reg_file_mp_if bus_nb ();

  reg_file_mp #(.BYPASS_EN(1)) dut    (.clk(clk), .rst(rst), .bus(bus));
  reg_file_mp #(.BYPASS_EN(0)) dut_nb (.clk(clk), .rst(rst), .bus(bus_nb));

  assign bus_nb.ra_addr_ep    = bus.ra_addr_ep;
  assign bus_nb.rb_addr_ep    = bus.rb_addr_ep;
  assign bus_nb.rc_addr_ep    = bus.rc_addr_ep;
  assign bus_nb.ra_addr_op    = bus.ra_addr_op;
  assign bus_nb.rb_addr_op    = bus.rb_addr_op;
  assign bus_nb.rc_addr_op    = bus.rc_addr_op;
  assign bus_nb.rt_addr_ep    = bus.rt_addr_ep;
  assign bus_nb.rt_addr_op    = bus.rt_addr_op;
  assign bus_nb.rt_wr_en_ep   = bus.rt_wr_en_ep;
  assign bus_nb.rt_wr_en_op   = bus.rt_wr_en_op;
  assign bus_nb.rt_wr_mask_ep = bus.rt_wr_mask_ep;
  assign bus_nb.rt_wr_mask_op = bus.rt_wr_mask_op;
  assign bus_nb.rt_wr_ep      = bus.rt_wr_ep;
  assign bus_nb.rt_wr_op      = bus.rt_wr_op;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [DATA_WD-1:0] mem [NUM_REGS];
  bit mvalid = 1'b0;
  bit mready = 1'b0;
  int mclr   = 0;
  bit mconf  = 1'b0;
  bit mdrop  = 1'b0;

  typedef struct {
    bit           en_ep;
    logic [6:0]   a_ep;
    logic [3:0]   m_ep;
    logic [127:0] d_ep;
    bit           en_op;
    logic [6:0]   a_op;
    logic [3:0]   m_op;
    logic [127:0] d_op;
    logic [6:0]   ra;
    logic [127:0] exp_byp;
    logic [127:0] exp_nb;
    bit           exp_conf;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected read value of one address for the current inputs.
  function automatic logic [127:0] exp_read(input logic [6:0] a, input bit bypass);
    logic [127:0] v;
    if (!mready) return '0;
    v = mem[a];
    if (bypass) begin
      for (int s = 0; s < 4; s++) begin
        if (bus.rt_wr_en_op && bus.rt_addr_op == a && bus.rt_wr_mask_op[s])
          v[s*32 +: 32] = bus.rt_wr_op[s*32 +: 32];
        else if (bus.rt_wr_en_ep && bus.rt_addr_ep == a && bus.rt_wr_mask_ep[s])
          v[s*32 +: 32] = bus.rt_wr_ep[s*32 +: 32];
      end
    end
    return v;
  endfunction

  task automatic compare();
    logic [6:0]   ad [6];
    logic [127:0] act [6];
    logic [127:0] act_nb [6];
    if (!mvalid) return;
    ad[0] = bus.ra_addr_ep; ad[1] = bus.rb_addr_ep; ad[2] = bus.rc_addr_ep;
    ad[3] = bus.ra_addr_op; ad[4] = bus.rb_addr_op; ad[5] = bus.rc_addr_op;
    act[0] = bus.ra_rd_ep; act[1] = bus.rb_rd_ep; act[2] = bus.rc_rd_ep;
    act[3] = bus.ra_rd_op; act[4] = bus.rb_rd_op; act[5] = bus.rc_rd_op;
    act_nb[0] = bus_nb.ra_rd_ep; act_nb[1] = bus_nb.rb_rd_ep; act_nb[2] = bus_nb.rc_rd_ep;
    act_nb[3] = bus_nb.ra_rd_op; act_nb[4] = bus_nb.rb_rd_op; act_nb[5] = bus_nb.rc_rd_op;
    check("init_busy", {127'd0, bus.init_busy}, {127'd0, !mready});
    check("wr_conflict", {127'd0, bus.wr_conflict}, {127'd0, mconf});
    check("wr_drop", {127'd0, bus.wr_drop}, {127'd0, mdrop});
    for (int p = 0; p < 6; p++) begin
      check($sformatf("rd_port%0d", p), act[p], exp_read(ad[p], 1'b1));
      check($sformatf("rd_nb_port%0d", p), act_nb[p], exp_read(ad[p], 1'b0));
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_update();
    if (rst) begin
      mvalid = 1'b1; mready = 1'b0; mclr = 0; mconf = 1'b0; mdrop = 1'b0;
    end else if (mvalid && !mready) begin
      for (int k = 0; k < 4; k++) mem[mclr*4 + k] = '0;
      mclr++;
      if (mclr == NCLRCYC) mready = 1'b1;
      mdrop = bus.rt_wr_en_ep || bus.rt_wr_en_op;
      mconf = 1'b0;
    end else if (mvalid) begin
      mdrop = 1'b0;
      mconf = bus.rt_wr_en_ep && bus.rt_wr_en_op && (bus.rt_addr_ep == bus.rt_addr_op)
              && ((bus.rt_wr_mask_ep & bus.rt_wr_mask_op) != 4'b0);
      for (int s = 0; s < 4; s++)
        if (bus.rt_wr_en_ep && bus.rt_wr_mask_ep[s]) mem[bus.rt_addr_ep][s*32 +: 32] = bus.rt_wr_ep[s*32 +: 32];
      for (int s = 0; s < 4; s++)
        if (bus.rt_wr_en_op && bus.rt_wr_mask_op[s]) mem[bus.rt_addr_op][s*32 +: 32] = bus.rt_wr_op[s*32 +: 32];
    end
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    finish_cycle();
  endtask

  task automatic set_wr(input bit en_ep, input logic [6:0] a_ep, input logic [3:0] m_ep, input logic [127:0] d_ep,
                        input bit en_op, input logic [6:0] a_op, input logic [3:0] m_op, input logic [127:0] d_op);
    bus.rt_wr_en_ep = en_ep; bus.rt_addr_ep = a_ep; bus.rt_wr_mask_ep = m_ep; bus.rt_wr_ep = d_ep;
    bus.rt_wr_en_op = en_op; bus.rt_addr_op = a_op; bus.rt_wr_mask_op = m_op; bus.rt_wr_op = d_op;
  endtask

  task automatic set_rd_all(input logic [6:0] a);
    bus.ra_addr_ep = a; bus.rb_addr_ep = a; bus.rc_addr_ep = a;
    bus.ra_addr_op = a; bus.rb_addr_op = a; bus.rc_addr_op = a;
  endtask

  task automatic idle();
    set_wr(1'b0, 7'd0, 4'h0, '0, 1'b0, 7'd0, 4'h0, '0);
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    while (bus.init_busy && n < 40) begin
      tick();
      n++;
    end
    check(name, 128'(n), 128'(NCLRCYC));
  endtask

  initial begin
    logic [127:0] o1, o2, o3, o4, abcd;
    o1 = {4{32'h1111_1111}}; o2 = {4{32'h2222_2222}};
    o3 = {4{32'h3333_3333}}; o4 = {4{32'h4444_4444}};
    abcd = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
    foreach (mem[i]) mem[i] = '0;

    tbl[0] = '{1, 7'd5, 4'hF, o1, 0, 7'd0, 4'h0, '0, 7'd5, o1, '0, 0};
    tbl[1] = '{0, 7'd0, 4'h0, '0, 0, 7'd0, 4'h0, '0, 7'd5, o1, o1, 0};
    tbl[2] = '{0, 7'd0, 4'h0, '0, 1, 7'd9, 4'b0011, abcd, 7'd9,
               128'h00000000_00000000_CCCCCCCC_DDDDDDDD, '0, 0};
    tbl[3] = '{1, 7'd3, 4'hF, o1, 1, 7'd3, 4'b0101, o2, 7'd3,
               {32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222}, '0, 1};
    tbl[4] = '{0, 7'd0, 4'h0, '0, 0, 7'd0, 4'h0, '0, 7'd3,
               {32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222},
               {32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222}, 0};
    tbl[5] = '{1, 7'd3, 4'b1100, o3, 1, 7'd3, 4'b0011, o4, 7'd3,
               {32'h33333333, 32'h33333333, 32'h44444444, 32'h44444444},
               {32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222}, 0};
    tbl[6] = '{1, 7'd3, 4'h0, {128{1'b1}}, 0, 7'd0, 4'h0, '0, 7'd3,
               {32'h33333333, 32'h33333333, 32'h44444444, 32'h44444444},
               {32'h33333333, 32'h33333333, 32'h44444444, 32'h44444444}, 0};
    tbl[7] = '{0, 7'd0, 4'h0, '0, 0, 7'd0, 4'h0, '0, 7'd9,
               128'h00000000_00000000_CCCCCCCC_DDDDDDDD,
               128'h00000000_00000000_CCCCCCCC_DDDDDDDD, 0};

    // Reset, then busy for exactly 32 cycles; r0 and r127 read zero.
    idle();
    set_rd_all(7'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("busy_after_rst", {127'd0, bus.init_busy}, 128'd1);
    count_busy("t1_busy_cycles");
    bus.ra_addr_ep = 7'd0;
    bus.rb_addr_op = 7'd127;
    @(negedge clk);
    check("t1_r0", bus.ra_rd_ep, '0);
    check("t1_r127", bus.rb_rd_op, '0);
    compare();
    finish_cycle();

    // Directed table: writes, bypass, merge and conflict cases.
    for (int i = 0; i < 8; i++) begin
      set_wr(tbl[i].en_ep, tbl[i].a_ep, tbl[i].m_ep, tbl[i].d_ep,
             tbl[i].en_op, tbl[i].a_op, tbl[i].m_op, tbl[i].d_op);
      set_rd_all(tbl[i].ra);
      @(negedge clk);
      check($sformatf("tbl%0d_ra_ep", i), bus.ra_rd_ep, tbl[i].exp_byp);
      check($sformatf("tbl%0d_rc_op", i), bus.rc_rd_op, tbl[i].exp_byp);
      check($sformatf("tbl%0d_nb_rb_op", i), bus_nb.rb_rd_op, tbl[i].exp_nb);
      compare();
      finish_cycle();
      check($sformatf("tbl%0d_conflict", i), {127'd0, bus.wr_conflict}, {127'd0, tbl[i].exp_conf});
    end

    // Randomized traffic on a small address window, occasional reset.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_wr($urandom_range(0, 1) == 1, 7'($urandom_range(0, 7)), 4'($urandom),
             {$urandom, $urandom, $urandom, $urandom},
             $urandom_range(0, 1) == 1, 7'($urandom_range(0, 7)), 4'($urandom),
             {$urandom, $urandom, $urandom, $urandom});
      bus.ra_addr_ep = 7'($urandom_range(0, 7)); bus.rb_addr_ep = 7'($urandom_range(0, 7));
      bus.rc_addr_ep = 7'($urandom_range(0, 7)); bus.ra_addr_op = 7'($urandom_range(0, 7));
      bus.rb_addr_op = 7'($urandom_range(0, 7)); bus.rc_addr_op = 7'($urandom_range(0, 7));
      tick();
    end

    // Reset reasserted mid-clear with a write pending.
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    set_wr(1'b1, 7'd20, 4'hF, {128{1'b1}}, 1'b0, 7'd0, 4'h0, '0);
    tick();
    check("t6_wr_drop_pulse", {127'd0, bus.wr_drop}, 128'd1);
    rst = 1'b1;
    tick();
    check("t6_wr_drop_cleared", {127'd0, bus.wr_drop}, 128'd0);
    check("t6_busy_restart", {127'd0, bus.init_busy}, 128'd1);
    rst = 1'b0;
    idle();
    count_busy("t6_busy_cycles");
    set_rd_all(7'd20);
    @(negedge clk);
    check("t6_r20_zero", bus.ra_rd_ep, '0);
    compare();
    finish_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
